fsm_q2_onehot_state: RTL and testbench
======================================

Name: fsm_q2_onehot_state

Overview:
- Registered state stage for the six-state (A–F) one-hot FSM driven by input w.
- Holds the one-hot state vector y[5:0] and computes the full next-state function internally. The Y1/Y3 next-state equations used elsewhere in the codebase are a subset of this function.
- Adds a Moore output z, illegal-state detection and recovery, a debug state-load port, and a count of entries into state D.
- Consumers read y[5:0] directly.

Parameters:
CNT_W, 8, width of the D-entry counter d_cnt (wraps modulo 2^CNT_W)

Ports:
clk  input  1  clock; all state updates on rising edge
resetn  input  1  synchronous reset, active-low
w  input  1  FSM input, sampled on rising edge of clk
ld  input  1  debug load strobe; when 1, the state register takes ld_state
ld_state  input  6  one-hot state value to load; may be illegal
y  output  6  registered one-hot state; bit0=A, bit1=B, bit2=C, bit3=D, bit4=E, bit5=F
z  output  1  Moore output; 1 in E or F
err  output  1  sticky flag; set when the register holds a non-one-hot value
d_cnt  output  CNT_W  number of entries into state D since reset, wrapping

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset is synchronous and active-low: on a rising edge of clk with resetn=0, y=6'b000001 (A), err=0, d_cnt=0.
  - Reset has priority over ld and over normal transitions.
  - Reset asserted mid-sequence returns the FSM to A on that edge, with no partial update of d_cnt.
- Priority on each rising edge with resetn=1: ld=1 first, then illegal-state recovery, then normal transition.
- Load (ld=1):
  - y <= ld_state verbatim, legal or not.
  - d_cnt is unchanged, even if ld_state is D.
  - err is unchanged on the load edge.
- Illegal state:
  - Legal means y has exactly one bit set.
  - While y is illegal: z=0.
  - On the next edge (ld=0): y <= A regardless of w, err <= 1, d_cnt unchanged.
  - err stays 1 until reset.
- Normal transitions (current state -> next state for w=0 / w=1):
  - A -> A / B
  - B -> D / C
  - C -> D / E
  - D -> A / F
  - E -> D / E
  - F -> D / C
- Next-state equations: next[0]=(A|D)&~w, next[1]=A&w, next[2]=(B|F)&w, next[3]=(B|C|E|F)&~w, next[4]=(C|E)&w, next[5]=D&w.
- d_cnt:
  - Increments by 1 on every normal transition whose next state is D.
  - D->D is impossible, so every increment is a true entry.
  - Wraps from 2^CNT_W-1 to 0 with no flag.
- Outputs:
  - z = (y[4]|y[5]) & legal. It is combinational from registered state: no dependence on w, zero-cycle latency relative to y.
  - y, err and d_cnt are registered.
  - A change in w affects y one edge later.

Test Plan:
- Reset behaviour: hold resetn=0 for 2 edges with w=1 and ld=1, ld_state=6'b010000 -> y=6'b000001, z=0, err=0, d_cnt=0 (reset beats ld).
- Walk from A, applying w per edge = 1,1,1,0,1,1,0,0:
  - y must step B(000010), C(000100), E(010000), D(001000), F(100000), C, D, A(000001).
  - z=1 exactly while y is E or F.
  - d_cnt=2 at the end, err=0.
- Self-loops:
  - In A, w=0 for 5 edges -> y stays 000001.
  - In E, w=1 for 5 edges -> y stays 010000, z=1 throughout, d_cnt unchanged.
- Illegal load, multi-hot:
  - ld=1, ld_state=6'b001010 -> y=001010, z=0, err=0.
  - Next edge with ld=0, w=1 -> y=000001, err=1.
  - err remains 1 across 10 further normal cycles, until resetn=0.
- Illegal load, zero: ld_state=6'b000000 -> same recovery to A, err=1.
- Counter wrap with CNT_W=2: cycle A->B->D->A four times (w=1,0,0 repeated) -> d_cnt sequence 1,2,3,0.
- Reset mid-operation: resetn=0 while in F with d_cnt=3 -> y=000001, d_cnt=0 on that edge.

Source files
------------

// File: rtl/fsm_q2_onehot_state.sv
// ============================================================================
// fsm_q2_onehot_state : registered one-hot A-F FSM with Moore z, illegal-state
// recovery, debug state load and D-entry counter.            Revision: 1.0
// ============================================================================
`default_nettype none

module fsm_q2_onehot_state #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             w,
   input  logic             ld,
   input  logic [5:0]       ld_state,
   output logic [5:0]       y,
   output logic             z,
   output logic             err,
   output logic [CNT_W-1:0] d_cnt
);

   typedef enum logic [5:0] {
      ST_A = 6'b000001,
      ST_B = 6'b000010,
      ST_C = 6'b000100,
      ST_D = 6'b001000,
      ST_E = 6'b010000,
      ST_F = 6'b100000
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             err_nxt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             legal;

   assign legal = $onehot(state);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= ST_A;
         err   <= 1'b0;
         d_cnt <= '0;
      end else begin
         state <= state_nxt;
         err   <= err_nxt;
         d_cnt <= cnt_nxt;
      end
   end

   // Load beats recovery, recovery beats the normal transition table.
   always_comb begin
      state_nxt = state;
      err_nxt   = err;
      cnt_nxt   = d_cnt;
      if (ld) begin
         state_nxt = state_t'(ld_state);
      end else if (!legal) begin
         state_nxt = ST_A;
         err_nxt   = 1'b1;
      end else begin
         case (state)
            ST_A:    state_nxt = w ? ST_B : ST_A;
            ST_B:    state_nxt = w ? ST_C : ST_D;
            ST_C:    state_nxt = w ? ST_E : ST_D;
            ST_D:    state_nxt = w ? ST_F : ST_A;
            ST_E:    state_nxt = w ? ST_E : ST_D;
            ST_F:    state_nxt = w ? ST_C : ST_D;
            default: state_nxt = ST_A;
         endcase
         // D has no self-loop, so landing in D is always a fresh entry.
         if (state_nxt == ST_D) begin
            cnt_nxt = d_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   assign y = state;
   assign z = (state[4] | state[5]) & legal;

endmodule

`default_nettype wire

// File: tb/tb_fsm_q2_onehot_state.sv
// ============================================================================
// tb_fsm_q2_onehot_state : directed bench with a table-driven reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fsm_q2_onehot_state;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       w = 1'b0;
   logic       ld = 1'b0;
   logic [5:0] ld_state = 6'b0;

   logic [5:0] y8, y2;
   logic       z8, z2, err8, err2;
   logic [7:0] cnt8;
   logic [1:0] cnt2;

   int checks = 0;
   int failures = 0;

   fsm_q2_onehot_state #(.CNT_W(8)) dut8 (
      .clk(clk), .resetn(resetn), .w(w), .ld(ld), .ld_state(ld_state),
      .y(y8), .z(z8), .err(err8), .d_cnt(cnt8)
   );

   fsm_q2_onehot_state #(.CNT_W(2)) dut2 (
      .clk(clk), .resetn(resetn), .w(w), .ld(ld), .ld_state(ld_state),
      .y(y2), .z(z2), .err(err2), .d_cnt(cnt2)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference model: state as a letter index, transitions from a lookup table.
   int         nxt_tbl [12] = '{0, 1,  3, 2,  3, 4,  0, 5,  3, 4,  3, 2};
   logic [5:0] m_y;
   bit         m_err;
   int         m_cnt;
   bit         m_valid = 0;

   function automatic int ones(input logic [5:0] v);
      int n = 0;
      for (int i = 0; i < 6; i++) n += int'(v[i]);
      return n;
   endfunction

   function automatic int idx_of(input logic [5:0] v);
      for (int i = 0; i < 6; i++) if (v[i]) return i;
      return 0;
   endfunction

   always @(posedge clk) begin
      int nx;
      if (!resetn) begin
         m_y = 6'b000001; m_err = 0; m_cnt = 0; m_valid = 1;
      end else if (m_valid) begin
         if (ld) begin
            m_y = ld_state;
         end else if (ones(m_y) != 1) begin
            m_y = 6'b000001; m_err = 1;
         end else begin
            nx = nxt_tbl[idx_of(m_y)*2 + int'(w)];
            if (nx == 3) m_cnt++;
            m_y = 6'(1 << nx);
         end
      end
   end

   always @(negedge clk) begin
      logic m_z;
      if (m_valid) begin
         m_z = (ones(m_y) == 1) && (idx_of(m_y) >= 4);
         check("model_y8",   32'(y8),   32'(m_y));
         check("model_y2",   32'(y2),   32'(m_y));
         check("model_z8",   32'(z8),   32'(m_z));
         check("model_z2",   32'(z2),   32'(m_z));
         check("model_err8", 32'(err8), 32'(m_err));
         check("model_err2", 32'(err2), 32'(m_err));
         check("model_cnt8", 32'(cnt8), 32'(m_cnt % 256));
         check("model_cnt2", 32'(cnt2), 32'(m_cnt % 4));
      end
   end

   task automatic step(input logic iw, input logic ild, input logic [5:0] ist, input logic irn);
      w = iw; ld = ild; ld_state = ist; resetn = irn;
      @(posedge clk);
      #1;
   endtask

   task automatic run(input logic iw);
      step(iw, 1'b0, 6'b0, 1'b1);
   endtask

   initial begin
      logic [5:0] walk_exp [8] = '{6'b000010, 6'b000100, 6'b010000, 6'b001000,
                                   6'b100000, 6'b000100, 6'b001000, 6'b000001};
      logic       walk_w   [8] = '{1, 1, 1, 0, 1, 1, 0, 0};

      // Reset beats load and w.
      step(1'b1, 1'b1, 6'b010000, 1'b0);
      step(1'b1, 1'b1, 6'b010000, 1'b0);
      check("rst_y", 32'(y8), 32'h01);
      check("rst_z", 32'(z8), 32'h0);
      check("rst_err", 32'(err8), 32'h0);
      check("rst_cnt", 32'(cnt8), 32'h0);

      // Walk A->B->C->E->D->F->C->D->A.
      for (int i = 0; i < 8; i++) begin
         run(walk_w[i]);
         check("walk_y", 32'(y8), 32'(walk_exp[i]));
         check("walk_z", 32'(z8), 32'((walk_exp[i] == 6'b010000) || (walk_exp[i] == 6'b100000)));
      end
      check("walk_cnt", 32'(cnt8), 32'd2);
      check("walk_err", 32'(err8), 32'h0);

      // Self-loops in A and E.
      for (int i = 0; i < 5; i++) run(1'b0);
      check("loopA_y", 32'(y8), 32'h01);
      run(1'b1); run(1'b1); run(1'b1);
      for (int i = 0; i < 5; i++) begin
         run(1'b1);
         check("loopE_y", 32'(y8), 32'h10);
         check("loopE_z", 32'(z8), 32'h1);
      end
      check("loopE_cnt", 32'(cnt8), 32'd2);

      // Loading D does not count as an entry.
      step(1'b0, 1'b1, 6'b001000, 1'b1);
      check("ldD_y", 32'(y8), 32'h08);
      check("ldD_cnt", 32'(cnt8), 32'd2);

      // Multi-hot load, recovery, sticky err.
      step(1'b1, 1'b1, 6'b001010, 1'b1);
      check("mh_y", 32'(y8), 32'h0a);
      check("mh_z", 32'(z8), 32'h0);
      check("mh_err", 32'(err8), 32'h0);
      run(1'b1);
      check("mh_rec_y", 32'(y8), 32'h01);
      check("mh_rec_err", 32'(err8), 32'h1);
      check("mh_rec_cnt", 32'(cnt8), 32'd2);
      for (int i = 0; i < 10; i++) run(1'(i % 3 != 2));
      check("mh_sticky", 32'(err8), 32'h1);
      step(1'b0, 1'b0, 6'b0, 1'b0);
      check("mh_clr", 32'(err8), 32'h0);

      // Zero load.
      step(1'b0, 1'b1, 6'b000000, 1'b1);
      check("zero_y", 32'(y8), 32'h00);
      check("zero_z", 32'(z8), 32'h0);
      run(1'b0);
      check("zero_rec_y", 32'(y8), 32'h01);
      check("zero_rec_err", 32'(err8), 32'h1);
      step(1'b0, 1'b0, 6'b0, 1'b0);

      // Wrap on the 2-bit counter: A->B->D->A four times.
      for (int i = 0; i < 4; i++) begin
         run(1'b1); run(1'b0);
         check("wrap_cnt2", 32'(cnt2), 32'((i + 1) % 4));
         run(1'b0);
      end
      check("wrap_cnt8", 32'(cnt8), 32'd4);
      step(1'b0, 1'b0, 6'b0, 1'b0);

      // Reach F with count 3, then reset mid-operation.
      for (int i = 0; i < 2; i++) begin run(1'b1); run(1'b0); run(1'b0); end
      run(1'b1); run(1'b0); run(1'b1);
      check("pre_rst_y", 32'(y8), 32'h20);
      check("pre_rst_cnt2", 32'(cnt2), 32'd3);
      step(1'b1, 1'b0, 6'b0, 1'b0);
      check("mid_rst_y", 32'(y8), 32'h01);
      check("mid_rst_cnt", 32'(cnt2), 32'd0);
      run(1'b0);

      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
